red_pitaya_xadc_drp_arb: RTL

Arbiter and sequencer for the XADC Dynamic Reconfiguration Port (DRP). It shares the single DRP between two requesters:
- automatic readout of each conversion result on End of Conversion (EOC);
- software read/write access to any DRP register (status, config, alarm limits), driven by a bus slave.

It sits between the XADC primitive and the AMS register block and enforces the DRP one-transaction-in-flight rule.

---
 rtl/red_pitaya_xadc_pkg.sv | 20 ++
 rtl/red_pitaya_xadc_drp_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_xadc_pkg.sv
// red_pitaya_xadc_pkg: shared types and constants for the XADC DRP arbiter.
package red_pitaya_xadc_pkg;

    typedef enum logic [1:0] {IDLE, AUTO_WAIT, SW_WAIT} state_t;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int CHAN_W = 5;

    localparam logic [ADDR_W-1:0] ADDR_TEMP    = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_VCCINT  = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_VCCAUX  = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_VPVN    = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_VCCBRAM = 7'h06;
    localparam logic [ADDR_W-1:0] ADDR_VCCPINT = 7'h0D;
    localparam logic [ADDR_W-1:0] ADDR_VCCPAUX = 7'h0E;
    localparam logic [ADDR_W-1:0] ADDR_VCCDDR  = 7'h0F;
    localparam logic [ADDR_W-1:0] ADDR_VAUX0   = 7'h10;

endpackage

// File: rtl/red_pitaya_xadc_drp_arb.sv
// red_pitaya_xadc_drp_arb: shares the XADC DRP between EOC auto-readout and software access.
// Define XADC_DRP_STATS_EN to enable the saturating overrun/timeout counter on stat_ovr_o.
module red_pitaya_xadc_drp_arb
    import red_pitaya_xadc_pkg::*;
#(
    parameter int TMO_W = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              xadc_eoc_i,
    input  logic [CHAN_W-1:0] xadc_channel_i,
    output logic [ADDR_W-1:0] drp_addr_o,
    output logic              drp_en_o,
    output logic              drp_we_o,
    output logic [DATA_W-1:0] drp_di_o,
    input  logic [DATA_W-1:0] drp_do_i,
    input  logic              drp_drdy_i,
    input  logic              sw_req_i,
    input  logic              sw_we_i,
    input  logic [ADDR_W-1:0] sw_addr_i,
    input  logic [DATA_W-1:0] sw_wdata_i,
    output logic              sw_busy_o,
    output logic              sw_ack_o,
    output logic              sw_err_o,
    output logic [DATA_W-1:0] sw_rdata_o,
    output logic              res_valid_o,
    output logic [CHAN_W-1:0] res_chan_o,
    output logic [11:0]       res_data_o,
    output logic [15:0]       stat_ovr_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t state_q, state_d;
    logic auto_pend_q, auto_pend_d, sw_pend_q, sw_pend_d, sw_we_q, sw_we_d;
    logic [CHAN_W-1:0] auto_chan_q, auto_chan_d, res_chan_q, res_chan_d;
    logic [ADDR_W-1:0] sw_addr_q, sw_addr_d, drp_addr_q, drp_addr_d;
    logic [DATA_W-1:0] sw_wdata_q, sw_wdata_d, drp_di_q, drp_di_d, sw_rdata_q, sw_rdata_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic sw_busy_q, sw_busy_d, drp_en_q, drp_en_d, drp_we_q, drp_we_d;
    logic sw_ack_q, sw_ack_d, sw_err_q, sw_err_d, res_valid_q, res_valid_d;
    logic [11:0] res_data_q, res_data_d;
    logic issue_auto, timeout;

    assign issue_auto = (state_q == IDLE) && auto_pend_q;
    assign timeout    = (tmo_q == TMO_LAST) && !drp_drdy_i;

    always_comb begin
        state_d     = state_q;
        auto_pend_d = auto_pend_q;
        auto_chan_d = auto_chan_q;
        sw_pend_d   = sw_pend_q;
        sw_we_d     = sw_we_q;
        sw_addr_d   = sw_addr_q;
        sw_wdata_d  = sw_wdata_q;
        drp_addr_d  = drp_addr_q;
        drp_we_d    = drp_we_q;
        drp_di_d    = drp_di_q;
        drp_en_d    = 1'b0;
        sw_ack_d    = 1'b0;
        sw_err_d    = sw_err_q;
        sw_rdata_d  = sw_rdata_q;
        res_valid_d = 1'b0;
        res_chan_d  = res_chan_q;
        res_data_d  = res_data_q;
        tmo_d       = (state_q == IDLE) ? '0 : tmo_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (auto_pend_q) begin
                    drp_en_d   = 1'b1;
                    drp_addr_d = {2'b00, auto_chan_q};
                    drp_we_d   = 1'b0;
                    drp_di_d   = '0;
                    state_d    = AUTO_WAIT;
                end else if (sw_pend_q) begin
                    drp_en_d   = 1'b1;
                    drp_addr_d = sw_addr_q;
                    drp_we_d   = sw_we_q;
                    drp_di_d   = sw_wdata_q;
                    state_d    = SW_WAIT;
                end
            end
            AUTO_WAIT: begin
                // drp_addr_q still holds the issued channel even if a newer EOC overwrote auto_chan_q
                if (drp_drdy_i) begin
                    res_valid_d = 1'b1;
                    res_chan_d  = drp_addr_q[CHAN_W-1:0];
                    res_data_d  = drp_do_i[15:4];
                    state_d     = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            SW_WAIT: begin
                if (drp_drdy_i || timeout) begin
                    sw_ack_d   = 1'b1;
                    sw_err_d   = !drp_drdy_i;
                    sw_rdata_d = drp_drdy_i ? drp_do_i : '0;
                    sw_pend_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (xadc_eoc_i) begin
            auto_pend_d = 1'b1;
            auto_chan_d = xadc_channel_i;
        end else if (issue_auto) begin
            auto_pend_d = 1'b0;
        end
        if (sw_req_i && !sw_busy_q) begin
            sw_pend_d  = 1'b1;
            sw_we_d    = sw_we_i;
            sw_addr_d  = sw_addr_i;
            sw_wdata_d = sw_wdata_i;
        end
        // busy covers the ack cycle so a new request cannot land on the completion strobe
        sw_busy_d = sw_pend_d || sw_ack_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            auto_pend_q <= 1'b0;
            auto_chan_q <= '0;
            sw_pend_q   <= 1'b0;
            sw_we_q     <= 1'b0;
            sw_addr_q   <= '0;
            sw_wdata_q  <= '0;
            sw_busy_q   <= 1'b0;
            tmo_q       <= '0;
            drp_addr_q  <= '0;
            drp_en_q    <= 1'b0;
            drp_we_q    <= 1'b0;
            drp_di_q    <= '0;
            sw_ack_q    <= 1'b0;
            sw_err_q    <= 1'b0;
            sw_rdata_q  <= '0;
            res_valid_q <= 1'b0;
            res_chan_q  <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            auto_pend_q <= auto_pend_d;
            auto_chan_q <= auto_chan_d;
            sw_pend_q   <= sw_pend_d;
            sw_we_q     <= sw_we_d;
            sw_addr_q   <= sw_addr_d;
            sw_wdata_q  <= sw_wdata_d;
            sw_busy_q   <= sw_busy_d;
            tmo_q       <= tmo_d;
            drp_addr_q  <= drp_addr_d;
            drp_en_q    <= drp_en_d;
            drp_we_q    <= drp_we_d;
            drp_di_q    <= drp_di_d;
            sw_ack_q    <= sw_ack_d;
            sw_err_q    <= sw_err_d;
            sw_rdata_q  <= sw_rdata_d;
            res_valid_q <= res_valid_d;
            res_chan_q  <= res_chan_d;
            res_data_q  <= res_data_d;
        end
    end

`ifdef XADC_DRP_STATS_EN
    logic        ovr, tmo_auto;
    logic [15:0] stat_q;
    logic [16:0] stat_sum;
    assign ovr      = xadc_eoc_i && auto_pend_q && !issue_auto;
    assign tmo_auto = (state_q == AUTO_WAIT) && timeout;
    assign stat_sum = {1'b0, stat_q} + {16'd0, ovr} + {16'd0, tmo_auto};
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) stat_q <= '0;
        else         stat_q <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
    end
    assign stat_ovr_o = stat_q;
`else
    assign stat_ovr_o = '0;
`endif

    assign drp_addr_o  = drp_addr_q;
    assign drp_en_o    = drp_en_q;
    assign drp_we_o    = drp_we_q;
    assign drp_di_o    = drp_di_q;
    assign sw_busy_o   = sw_busy_q;
    assign sw_ack_o    = sw_ack_q;
    assign sw_err_o    = sw_err_q;
    assign sw_rdata_o  = sw_rdata_q;
    assign res_valid_o = res_valid_q;
    assign res_chan_o  = res_chan_q;
    assign res_data_o  = res_data_q;

endmodule
